// File: rtl/pmem_responder.sv
// pmem_responder
//   Line-granular physical-memory stand-in for the L2 / eviction-write-buffer
//   side of the CPU. It serves one 128-bit line request at a time. The latency
//   depends on whether the request falls in the currently open DRAM row.
//
//   Handshake: the initiator raises pmem_read or pmem_write and holds it with
//   a stable address until pmem_resp pulses for one cycle. The request is
//   sampled only in IDLE. Once it is accepted, the address and data inputs are
//   don't-care. The initiator drops its request in the cycle after pmem_resp,
//   so it is never seen again as a fresh request.
//
//   Ports
//     clk, rst_n                 rising-edge clock, async active-low reset
//     pmem_read, pmem_write      request strobes (both high => write + error)
//     pmem_address[15:0]         byte address, bits [3:0] ignored
//     pmem_wdata[127:0]          write line data
//     pmem_resp                  one-cycle completion pulse
//     pmem_rdata[127:0]          last read line, held until the next read
//     busy                       high while a request is in flight (BUSY/RESP)
//     protocol_err               sticky: read and write accepted together
//     read_count, write_count    completed reads / writes, wrap at 2^16
//     row_hit_count              accepted requests that hit the open row
module pmem_responder #(
   parameter int LINE_BITS = 12,
   parameter int ROW_LSB   = 8,
   parameter int HIT_LAT   = 4,
   parameter int MISS_LAT  = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy,
   output logic         protocol_err,
   output logic [15:0]  read_count,
   output logic [15:0]  write_count,
   output logic [15:0]  row_hit_count
);

   localparam int ROW_BITS = 16 - ROW_LSB;
   // The counter is loaded with L-1 because the acceptance edge itself is the
   // first of the L cycles.
   localparam logic [7:0] HIT_LOAD  = 8'(HIT_LAT - 1);
   localparam logic [7:0] MISS_LOAD = 8'(MISS_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state;
   logic [7:0]           lat_cnt;
   logic [LINE_BITS-1:0] line_q;
   logic                 op_write_q;
   logic [127:0]         wdata_q;
   logic [ROW_BITS-1:0]  open_row;
   logic                 open_valid;

   // Backing store: no reset, so unwritten lines read as X in simulation.
   logic [127:0]         mem [2**LINE_BITS];

   logic                 req;
   logic [ROW_BITS-1:0]  row_in;
   logic [LINE_BITS-1:0] line_in;
   logic                 row_hit;
   logic                 commit;
   logic                 unused_addr_bits;

   assign req     = pmem_read | pmem_write;
   assign row_in  = pmem_address[15:ROW_LSB];
   assign line_in = pmem_address[LINE_BITS+3:4];
   assign row_hit = open_valid && (row_in == open_row);
   // A write lands in the array on the last BUSY edge, the same edge that
   // enters RESP. A reset before that edge leaves the state machine in IDLE,
   // so the pending write is dropped.
   assign commit  = (state == ST_BUSY) && (lat_cnt == 8'd0) && op_write_q;
   assign unused_addr_bits = ^pmem_address[3:0];

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[line_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         lat_cnt       <= 8'd0;
         line_q        <= '0;
         op_write_q    <= 1'b0;
         wdata_q       <= '0;
         open_row      <= '0;
         open_valid    <= 1'b0;
         pmem_resp     <= 1'b0;
         pmem_rdata    <= '0;
         busy          <= 1'b0;
         protocol_err  <= 1'b0;
         read_count    <= 16'd0;
         write_count   <= 16'd0;
         row_hit_count <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  line_q     <= line_in;
                  op_write_q <= pmem_write;
                  wdata_q    <= pmem_wdata;
                  lat_cnt    <= row_hit ? HIT_LOAD : MISS_LOAD;
                  if (row_hit) begin
                     row_hit_count <= row_hit_count + 16'd1;
                  end
                  open_row   <= row_in;
                  open_valid <= 1'b1;
                  if (pmem_read && pmem_write) begin
                     protocol_err <= 1'b1;
                  end
                  busy  <= 1'b1;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (lat_cnt == 8'd0) begin
                  // Reads see the old contents; a write's commit and a read's
                  // fetch never happen on the same edge.
                  if (!op_write_q) begin
                     pmem_rdata <= mem[line_q];
                  end
                  pmem_resp <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 8'd1;
               end
            end
            ST_RESP: begin
               pmem_resp <= 1'b0;
               busy      <= 1'b0;
               if (op_write_q) begin
                  write_count <= write_count + 16'd1;
               end else begin
                  read_count <= read_count + 16'd1;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder
//   Drives directed and randomized line requests into pmem_responder. A
//   timestamp-based reference model decides when each request is accepted,
//   what its latency is, and what the array holds. It also tracks what every
//   output must show. A compare process checks all outputs on every falling
//   edge. Directed sequences additionally pin latencies and data to
//   hand-computed literals.
module tb_pmem_responder;

   localparam int HIT_LAT  = 4;
   localparam int MISS_LAT = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;
   logic         busy;
   logic         protocol_err;
   logic [15:0]  read_count;
   logic [15:0]  write_count;
   logic [15:0]  row_hit_count;

   pmem_responder #(
      .LINE_BITS(12),
      .ROW_LSB  (8),
      .HIT_LAT  (HIT_LAT),
      .MISS_LAT (MISS_LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata),
      .busy         (busy),
      .protocol_err (protocol_err),
      .read_count   (read_count),
      .write_count  (write_count),
      .row_hit_count(row_hit_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Requests are described by timestamps: accepted at edge m_acc, response
   // during the cycle after edge m_acc+m_lat, retired at edge m_acc+m_lat+1.
   logic [127:0] m_mem [int];
   int           edge_n;
   bit           m_active;
   int           m_acc;
   int           m_lat;
   bit           m_write;
   int           m_line;
   logic [127:0] m_data;
   bit           m_open_valid;
   int           m_open_row;
   logic [127:0] m_rdata;
   bit           m_rdata_known;
   logic [15:0]  m_rd_cnt;
   logic [15:0]  m_wr_cnt;
   logic [15:0]  m_hit_cnt;
   bit           m_perr;

   task automatic model_reset();
      edge_n        = 0;
      m_active      = 0;
      m_open_valid  = 0;
      m_open_row    = 0;
      m_rdata       = '0;
      m_rdata_known = 1;
      m_rd_cnt      = 0;
      m_wr_cnt      = 0;
      m_hit_cnt     = 0;
      m_perr        = 0;
   endtask

   task automatic model_step();
      bit was_idle;
      int row;
      bit hit;
      was_idle = !m_active;
      edge_n++;
      if (m_active && edge_n == m_acc + m_lat) begin
         if (m_write) begin
            m_mem[m_line] = m_data;
         end else if (m_mem.exists(m_line)) begin
            m_rdata       = m_mem[m_line];
            m_rdata_known = 1;
         end else begin
            m_rdata_known = 0;
         end
      end
      if (m_active && edge_n == m_acc + m_lat + 1) begin
         if (m_write) m_wr_cnt = m_wr_cnt + 16'd1;
         else         m_rd_cnt = m_rd_cnt + 16'd1;
         m_active = 0;
      end
      if (was_idle && (pmem_read || pmem_write)) begin
         row = int'(pmem_address[15:8]);
         hit = m_open_valid && (row == m_open_row);
         m_lat = hit ? HIT_LAT : MISS_LAT;
         if (hit) m_hit_cnt = m_hit_cnt + 16'd1;
         m_open_row   = row;
         m_open_valid = 1;
         m_write      = pmem_write;
         if (pmem_read && pmem_write) m_perr = 1;
         m_line   = int'(pmem_address[15:4]);
         m_data   = pmem_wdata;
         m_acc    = edge_n;
         m_active = 1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst_n === 1'b1) model_step();
      end
   end

   // ---------------- scoreboard: compare every cycle ----------------
   task automatic compare_outputs();
      logic exp_resp;
      exp_resp = m_active && (edge_n == m_acc + m_lat);
      check("resp", pmem_resp, exp_resp);
      check("busy", busy, m_active);
      check("protocol_err", protocol_err, m_perr);
      check("read_count", read_count, m_rd_cnt);
      check("write_count", write_count, m_wr_cnt);
      check("row_hit_count", row_hit_count, m_hit_cnt);
      if (m_rdata_known) check("rdata", pmem_rdata, m_rdata);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         compare_outputs();
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; outputs must already be at reset values.
   task automatic do_reset();
      rst_n      = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      model_reset();
      #1;
      check("rst_resp", pmem_resp, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdata", pmem_rdata, 128'd0);
      check("rst_perr", protocol_err, 1'b0);
      check("rst_counts", {read_count, write_count, row_hit_count}, 48'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One request. lat returns accept-to-response cycles, 0 if aborted by
   // reset after abort_after cycles, -1 on timeout. With scramble set, the
   // address and data are disturbed every cycle after acceptance.
   task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [127:0] data, input bit scramble,
                         input int abort_after, output int lat);
      settle();
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = data;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
         settle();
         if (pmem_resp === 1'b1) begin
            lat = k;
            break;
         end
         if (scramble) begin
            pmem_address = pmem_address ^ 16'h0010;
            pmem_wdata   = ~pmem_wdata;
         end
         if (abort_after == k) begin
            do_reset();
            lat = 0;
            break;
         end
      end
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL timeout: no pmem_resp within 300 cycles for addr %0h", addr);
      end
   endtask

   // ---------------- main sequence ----------------
   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] DA = {16{8'hAA}};
   localparam logic [127:0] D3 = 128'h33333333_C0FFEE00_33333333_12345678;
   localparam logic [127:0] D4 = 128'h44444444_DEADBEEF_44444444_87654321;
   localparam logic [127:0] D5 = 128'h55555555_55555555_55555555_55555555;
   localparam logic [127:0] D6 = 128'h66666666_0BADF00D_66666666_FEEDFACE;

   initial begin
      int lat;
      rst_n        = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'd0;
      pmem_wdata   = '0;
      model_reset();
      settle();
      do_reset();

      // first access after reset is a miss
      do_req(1, 0, 16'h0040, '0, 0, 0, lat);
      check("t1_lat", lat, 10);
      settle();
      check("t1_read_count", read_count, 16'd1);
      check("t1_hit_count", row_hit_count, 16'd0);

      // write then read the same line, both open-row hits
      do_req(0, 1, 16'h0040, D1, 0, 0, lat);
      check("t2_wr_lat", lat, 4);
      do_req(1, 0, 16'h0040, '0, 0, 0, lat);
      check("t2_rd_lat", lat, 4);
      check("t2_rdata", pmem_rdata, D1);
      settle();
      check("t2_write_count", write_count, 16'd1);
      check("t2_hit_count", row_hit_count, 16'd2);

      // row miss / row miss / row hit
      settle();
      do_reset();
      do_req(1, 0, 16'h0040, '0, 0, 0, lat);
      check("t3_lat_a", lat, 10);
      do_req(1, 0, 16'h0140, '0, 0, 0, lat);
      check("t3_lat_b", lat, 10);
      do_req(1, 0, 16'h0150, '0, 0, 0, lat);
      check("t3_lat_c", lat, 4);

      // read+write together: treated as write, sticky error
      do_req(1, 1, 16'h0200, DA, 0, 0, lat);
      check("t4_lat", lat, 10);
      settle();
      check("t4_perr", protocol_err, 1'b1);
      do_req(1, 0, 16'h0200, '0, 0, 0, lat);
      check("t4_rdata", pmem_rdata, DA);
      check("t4_perr_sticky", protocol_err, 1'b1);

      // inputs disturbed during BUSY have no effect
      do_req(0, 1, 16'h0310, D4, 0, 0, lat);
      do_req(0, 1, 16'h0300, D3, 1, 0, lat);
      check("t5_wr_lat", lat, 4);
      do_req(1, 0, 16'h0300, '0, 0, 0, lat);
      check("t5_rdata_target", pmem_rdata, D3);
      do_req(1, 0, 16'h0310, '0, 0, 0, lat);
      check("t5_rdata_neighbour", pmem_rdata, D4);

      // reset mid-BUSY discards the pending write
      do_req(0, 1, 16'h0400, D6, 0, 0, lat);
      do_req(0, 1, 16'h0400, D5, 0, 3, lat);
      check("t6_aborted", lat, 0);
      do_req(1, 0, 16'h0400, '0, 0, 0, lat);
      check("t6_lat", lat, 10);
      check("t6_rdata", pmem_rdata, D6);

      // randomized traffic over 4 rows x 4 lines so hits and misses mix
      for (int i = 0; i < 150; i++) begin
         logic [15:0] addr;
         int          op;
         addr = {6'd0, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)), 4'($urandom)};
         op   = $urandom_range(0, 19);
         if (op < 9)       do_req(1, 0, addr, rand128(), $urandom_range(0, 1) == 1, 0, lat);
         else if (op < 18) do_req(0, 1, addr, rand128(), $urandom_range(0, 1) == 1, 0, lat);
         else              do_req(1, 1, addr, rand128(), 0, 0, lat);
      end

      repeat (3) settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
